// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode/execute boundary: opcodes, funct codes,
// ALU control codes and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] alu_ctrl;
    logic       b_imm;
  } ctrl_t;

  // Forms whose rt field is a true source operand (and so can cause a load-use stall).
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing the execute-stage control bundle.
// Unrecognised encodings yield an invalid bundle with the ADD code.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl          = '0;
    o_ctrl.alu_ctrl = ALU_ADD;
    unique case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.valid  = 1'b1;
        o_ctrl.reg_wr = 1'b1;
        unique case (i_funct)
          FN_ADD:  o_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  o_ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  o_ctrl.alu_ctrl = ALU_AND;
          FN_OR:   o_ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  o_ctrl.alu_ctrl = ALU_SLT;
          default: begin
            o_ctrl.valid  = 1'b0;
            o_ctrl.reg_wr = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        o_ctrl.valid  = 1'b1;
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.b_imm  = 1'b1;
      end
      OP_LW: begin
        o_ctrl.valid  = 1'b1;
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.mem_rd = 1'b1;
        o_ctrl.b_imm  = 1'b1;
      end
      OP_SW: begin
        o_ctrl.valid  = 1'b1;
        o_ctrl.mem_wr = 1'b1;
        o_ctrl.b_imm  = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.valid    = 1'b1;
        o_ctrl.alu_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode, operand forwarding, load-use stall detection,
// and bubble insertion on stall, flush or an empty/undecodable slot.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_res,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_res,
  input  logic          flush,
  output logic          stall_req,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [2:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_rt_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_wr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr
);

  ctrl_t         w_ctrl;
  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_rt;
  logic [RW-1:0] w_dest;
  logic          w_rs_hit;
  logic          w_rt_hit;
  logic          w_bubble;

  logic          r_valid;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [2:0]    r_alu_ctrl;
  logic [DW-1:0] r_rt_data;
  logic [RW-1:0] r_dest;
  logic          r_reg_wr;
  logic          r_mem_rd;
  logic          r_mem_wr;

  alu_decode u_alu_decode (
    .i_opcode (id_opcode),
    .i_funct  (id_funct),
    .o_ctrl   (w_ctrl)
  );

  // EX/MEM has priority over MEM/WB; r0 is never forwarded.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] addr, input logic [DW-1:0] rf);
    if (addr == '0)                         return rf;
    else if (exmem_wr && exmem_rd == addr) return exmem_res;
    else if (memwb_wr && memwb_rd == addr) return memwb_res;
    else                                    return rf;
  endfunction

  assign w_sext   = {{(DW-16){id_imm[15]}}, id_imm};
  assign w_fwd_a  = fwd(id_rs, id_rs_data);
  assign w_fwd_rt = fwd(id_rt, id_rt_data);
  assign w_dest   = !w_ctrl.reg_wr ? '0 : (id_opcode == OP_RTYPE) ? id_rd : id_rt;

  assign w_rs_hit  = (r_dest == id_rs);
  assign w_rt_hit  = (r_dest == id_rt) && uses_rt(id_opcode);
  assign stall_req = r_valid && r_mem_rd && (r_dest != '0) && id_valid && (w_rs_hit || w_rt_hit);

  assign w_bubble = flush || stall_req || !id_valid || !w_ctrl.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu_ctrl <= 3'b000;
      r_rt_data  <= '0;
      r_dest     <= '0;
      r_reg_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu_ctrl <= ALU_ADD;
      r_rt_data  <= '0;
      r_dest     <= '0;
      r_reg_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else begin
      r_valid    <= 1'b1;
      r_a        <= w_fwd_a;
      r_b        <= w_ctrl.b_imm ? w_sext : w_fwd_rt;
      r_alu_ctrl <= w_ctrl.alu_ctrl;
      r_rt_data  <= w_fwd_rt;
      r_dest     <= w_dest;
      r_reg_wr   <= w_ctrl.reg_wr;
      r_mem_rd   <= w_ctrl.mem_rd;
      r_mem_wr   <= w_ctrl.mem_wr;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_a        = r_a;
  assign ex_b        = r_b;
  assign ex_alu_ctrl = r_alu_ctrl;
  assign ex_rt_data  = r_rt_data;
  assign ex_dest     = r_dest;
  assign ex_reg_wr   = r_reg_wr;
  assign ex_mem_rd   = r_mem_rd;
  assign ex_mem_wr   = r_mem_wr;

endmodule
